approx_cpa_pipe: RTL and testbench

//  Final carry-propagate stage of the approximate multiplier datapath. Consumes the two

---
 rtl/approx_cpa_pipe.sv | 96 +++++++++
 tb/tb_approx_cpa_pipe.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/approx_cpa_pipe.sv
// Final carry-propagate adder of the approximate multiplier: two-stage pipelined add
// of the compressor-tree residual rows with valid/ready handshake on both sides.
module approx_cpa_pipe #(
  parameter int WIDTH = 16,
  parameter int SPLIT = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] row_a,
  input  logic [WIDTH-1:0] row_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] prod,
  output logic             prod_ovf,
  output logic [CNT_W-1:0] res_count
);

  localparam int HW = WIDTH - SPLIT;

  logic             s1_valid;
  logic [SPLIT-1:0] s1_lo;
  logic             s1_c;
  logic [HW-1:0]    s1_a_hi;
  logic [HW-1:0]    s1_b_hi;

  logic s2_free;
  logic s1_adv;
  logic in_fire;
  logic out_fire;

  // Handshake and advance conditions; in_ready follows out_ready with no skid buffer.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    s1_adv   = s1_valid && s2_free;
    in_ready = !rst && (!s1_valid || s2_free);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
  end

  // Stage 1: low-slice add with carry, high slices passed through.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lo    <= '0;
      s1_c     <= 1'b0;
      s1_a_hi  <= '0;
      s1_b_hi  <= '0;
    end else begin
      s1_valid <= in_fire || (s1_valid && !s2_free);
      if (in_fire) begin
        {s1_c, s1_lo} <= {1'b0, row_a[SPLIT-1:0]} + {1'b0, row_b[SPLIT-1:0]};
        s1_a_hi       <= row_a[WIDTH-1:SPLIT];
        s1_b_hi       <= row_b[WIDTH-1:SPLIT];
      end else begin
        s1_c    <= s1_c;
        s1_lo   <= s1_lo;
        s1_a_hi <= s1_a_hi;
        s1_b_hi <= s1_b_hi;
      end
    end
  end

  // Stage 2: high-slice add absorbing the registered low carry; holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      prod      <= '0;
      prod_ovf  <= 1'b0;
    end else begin
      out_valid <= s1_adv || (out_valid && !out_ready);
      if (s1_adv) begin
        {prod_ovf, prod[WIDTH-1:SPLIT]} <= {1'b0, s1_a_hi} + {1'b0, s1_b_hi}
                                           + {{HW{1'b0}}, s1_c};
        prod[SPLIT-1:0] <= s1_lo;
      end else begin
        prod     <= prod;
        prod_ovf <= prod_ovf;
      end
    end
  end

  // Completed-result counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_count <= '0;
    end else if (out_fire) begin
      res_count <= res_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      res_count <= res_count;
    end
  end

endmodule

// File: tb/tb_approx_cpa_pipe.sv
// Self-checking bench for approx_cpa_pipe: directed steps plus random stream,
// scored against an in-order queue of exact (A+B) sums.
module tb_approx_cpa_pipe;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] row_a = '0;
  logic [W-1:0] row_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] prod;
  logic         prod_ovf;
  logic [15:0]  res_count;

  approx_cpa_pipe #(.WIDTH(W), .SPLIT(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .row_a(row_a), .row_b(row_b), .out_valid(out_valid), .out_ready(out_ready),
    .prod(prod), .prod_ovf(prod_ovf), .res_count(res_count)
  );

  always #5 clk = ~clk;

  int           n_chk  = 0;
  int           n_fail = 0;
  int           cnt    = 0;
  bit           accepted;
  logic [W:0]   q[$];
  logic [W:0]   exp_sum;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    bit clr;
    clr = 1'b0;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, rst ? 32'd0 : ((q.size() < 2 || out_ready) ? 32'd1 : 32'd0));
    chk("res_count", {16'd0, res_count}, cnt);
    if (q.size() == 0) chk("idle_out_valid", {31'd0, out_valid}, 32'd0);
    accepted = 1'b0;
    if (rst) begin
      clr = 1'b1;
    end else begin
      if (out_valid && out_ready && q.size() > 0) begin
        exp_sum = q.pop_front();
        chk("prod", {15'd0, prod_ovf, prod}, {15'd0, exp_sum});
        cnt++;
      end
      if (in_valid && in_ready) begin
        q.push_back({1'b0, row_a} + {1'b0, row_b});
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (clr) begin
      q.delete();
      cnt = 0;
    end
  endtask

  int idx;

  initial begin
    // 1: reset with in_valid asserted
    rst = 1'b1; in_valid = 1'b1; row_a = 16'h1234; row_b = 16'h1111; out_ready = 1'b1;
    tick();
    tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_prod", {15'd0, prod_ovf, prod}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // 2: latency, carry across the split boundary
    in_valid = 1'b1; row_a = 16'h00FF; row_b = 16'h0001;
    tick();
    in_valid = 1'b0;
    chk("lat_t1_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("lat_t2_out_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_prod", {15'd0, prod_ovf, prod}, 32'h00100);
    tick();

    // 3: overflow and wrap
    in_valid = 1'b1; row_a = 16'hFFFF; row_b = 16'h0001;
    tick();
    row_a = 16'h8000; row_b = 16'h8000;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ovf1_prod", {15'd0, prod_ovf, prod}, 32'h10000);
    tick();
    chk("ovf2_prod", {15'd0, prod_ovf, prod}, 32'h10000);
    tick();

    // 4: backpressure
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; idx = 0;
    for (int i = 0; i < 5; i++) begin
      row_a = 16'(idx + 1); row_b = 16'(idx + 1);
      tick();
      if (accepted) idx++;
      if (i >= 2) chk("bp_hold_prod", {15'd0, prod_ovf, prod}, 32'h00002);
    end
    chk("bp_accepted", idx, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      row_a = 16'(idx + 1); row_b = 16'(idx + 1);
      tick();
      if (accepted) idx++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    chk("bp_drained", q.size(), 32'd0);
    chk("bp_res_count", {16'd0, res_count}, 32'd4);

    // 5: full throughput random stream
    rst = 1'b1; tick(); rst = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; idx = 0;
    for (int i = 0; i < 100; i++) begin
      row_a = 16'($urandom); row_b = 16'($urandom);
      tick();
      if (accepted) idx++;
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("tp_accepted", idx, 32'd100);
    chk("tp_res_count", {16'd0, res_count}, 32'd100);

    // 6: reset with two results in flight
    out_ready = 1'b0; in_valid = 1'b1; row_a = 16'h0AAA; row_b = 16'h0555;
    tick();
    row_a = 16'h7000; row_b = 16'h9001;
    tick();
    chk("mf_inflight", q.size(), 32'd2);
    in_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mf_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mf_res_count", {16'd0, res_count}, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mf_no_stale", {16'd0, res_count}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
